uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmitter for the UART command link: the transmit direction paired with the existing UART receive path. Accepts bytes from the command interface into a small FIFO and serialises each as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on `uart_tx`. Idle level is 1. Sits between the command/response logic and the board TX pin, sharing the same `BAUD_RATE`/`CLK_FREQ` parameters as the receiver.

## Interface
- `BAUD_RATE`, 115200, serial bit rate.
- `CLK_FREQ`, 50000000, `clk` frequency in Hz.
- `FIFO_DEPTH`, 4, byte FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `com_valid`  in  1  write request; byte on `com_wdata` is offered.
- `com_wdata`  in  8  byte to transmit.
- `com_ready`  out  1  FIFO can accept; transfer occurs when `com_valid && com_ready` at a rising edge.
- `uart_tx`  out  1  serial output, registered.
- `tx_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- `BIT_PERIOD = CLK_FREQ / BAUD_RATE` (integer division); the bit counter is 16 bits wide, and `BIT_PERIOD` must be ≥ 2.
- FIFO:
  - Circular buffer with `$clog2(FIFO_DEPTH)`-bit read/write pointers that wrap naturally, plus an occupancy count.
  - `com_ready = (count != FIFO_DEPTH)`, combinational from the count.
  - Push and pop in the same cycle leave the count unchanged.
  - A push while full cannot occur, because `com_ready` is low.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the clock and bit counters, and go to START.
  - START: `uart_tx`=0 for `BIT_PERIOD` clocks, then go to DATA.
  - DATA: drive `shift[0]` for `BIT_PERIOD` clocks, then shift right. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: drive the even-parity bit for `BIT_PERIOD` clocks, then go to STOP.
  - STOP: `uart_tx`=1 for `BIT_PERIOD` clocks. On the last stop cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- `tx_busy = (state != IDLE) || (count != 0)`.
- Reset mid-frame: on the next edge `uart_tx`=1, the state is IDLE, the FIFO is flushed, and the partial frame is abandoned.

## Timing
- Reset values: `uart_tx`=1, `com_ready`=1, `tx_busy`=0, FIFO empty, state IDLE, counters 0.
- Latency from an idle, empty FIFO, with the accepting edge at N:
  - count=1 after N.
  - Pop at edge N+1.
  - `uart_tx` falls after edge N+2.
- Each bit lasts exactly `BIT_PERIOD` clocks.
- Frame length is 10·`BIT_PERIOD` clocks, or 11·`BIT_PERIOD` with parity.
- Back-to-back frames are contiguous: the start bit of frame k+1 follows the last stop cycle of frame k immediately.
- Throughput is limited only by the line rate; the FIFO absorbs bursts of up to `FIFO_DEPTH` bytes plus one in the shifter.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in, and an even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and stop.
  - Frame is 8E1, 11 bits.
- Undefined:
  - The PARITY state and parity logic are absent.
  - Frame is 8N1, 10 bits.
- The receiver must be built with the matching setting.

## Test plan
All tests use `CLK_FREQ`=1600, `BAUD_RATE`=100, so `BIT_PERIOD`=16.
- Single byte 0xA5 pushed while idle:
  - `uart_tx` falls 2 clocks after accept.
  - Mid-bit samples (every 16 clocks from offset 8) read 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` drops after 160 clocks of frame.
- Burst: `com_valid` held high with bytes 0x01–0x06 on consecutive cycles from idle:
  - Exactly 5 bytes accepted before `com_ready` goes low.
  - `com_ready` reasserts one cycle after the first stop-bit end.
  - All 6 bytes appear in order as contiguous frames, 960 clocks total with no idle gap.
- Data-path corners 0x00 and 0xFF back-to-back:
  - 0x00 gives 9 consecutive zero samples then stop.
  - 0xFF gives start 0 then 9 ones.
  - The next start bit falls exactly 16 clocks after the 0xFF stop bit begins.
- Reset asserted for one cycle at bit 3 of a frame, with 2 bytes queued:
  - `uart_tx`=1 and `tx_busy`=0 on the next edge.
  - No further frames are sent.
  - `com_ready`=1.
- With `UART_TX_PARITY_EN`:
  - 0xA5 yields parity sample 0.
  - 0x07 yields parity sample 1.
  - Frame length is 176 clocks.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter
//
// Transmit half of the UART command link. Bytes offered on the command
// interface are queued in a small circular FIFO and serialised one at a time
// onto uart_tx as asynchronous frames. Each frame is a start bit (0), eight
// data bits LSB first and a stop bit (1). The line idles high.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When it is defined, an even-parity bit (XOR of the eight data bits) is
//   inserted between data bit 7 and the stop bit, which gives an 8E1 frame.
//   When it is undefined, the frame is 8N1 and no parity logic is built.
//   The receiver must be built with the same setting.
//
// Parameters:
//   BAUD_RATE   serial bit rate
//   CLK_FREQ    clk frequency in Hz; CLK_FREQ / BAUD_RATE must be >= 2
//   FIFO_DEPTH  byte FIFO entries; must be a power of two and >= 2
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rst        synchronous, active-high reset; flushes the FIFO and abandons
//              any partial frame
//   com_valid  write request; the byte on com_wdata is offered
//   com_wdata  byte to transmit
//   com_ready  FIFO can accept; a transfer occurs when com_valid && com_ready
//              are both high at a rising edge
//   uart_tx    registered serial output
//   tx_busy    high while a frame is in progress or the FIFO holds bytes

module uart_transmitter #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       com_valid,
  input  logic [7:0] com_wdata,
  output logic       com_ready,
  output logic       uart_tx,
  output logic       tx_busy
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [15:0]      BIT_LAST = 16'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             uart_tx_q, uart_tx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [7:0] fifo_head;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       bit_done;

  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign push       = com_valid && com_ready;
  assign bit_done   = (clk_cnt_q == BIT_LAST);

  assign com_ready = (count_q != FULL_CNT);
  assign tx_busy   = (state_q != ST_IDLE) || !fifo_empty;
  assign uart_tx   = uart_tx_q;

  // FIFO storage has no reset; only the pointers and the count define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= com_wdata;
    end
  end

  // Pointer and occupancy bookkeeping. The pointers are exactly log2(depth)
  // bits wide, so they wrap without any explicit compare. A simultaneous
  // push and pop leaves the count where it was.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer. The line level chosen here is registered, so uart_tx
  // trails the state by one clock. Every bit still lasts BIT_PERIOD clocks.
  // A pop happens either from IDLE or on the last stop-bit clock. Popping on
  // the last stop-bit clock makes back-to-back frames contiguous on the line.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    uart_tx_d = 1'b1;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        uart_tx_d = 1'b1;
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end

      ST_START: begin
        uart_tx_d = 1'b0;
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        uart_tx_d = shift_q[0];
        if (bit_done) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        uart_tx_d = parity_q;
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
`endif

      ST_STOP: begin
        uart_tx_d = 1'b1;
        if (bit_done) begin
          clk_cnt_d = '0;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Loading the next byte is shared by both pop sites. The parity of the
    // byte is captured here because the shift register is consumed bit by bit.
    if (pop) begin
      shift_d   = fifo_head;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^fifo_head;
`endif
    end
  end

  // State register. Reset forces the line high, flushes the FIFO and
  // abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//
// Scoreboard bench for uart_transmitter. The stimulus side pushes each
// accepted byte into an expected queue. An independent line monitor decodes
// uart_tx like a receiver, sampling each bit at its middle. It pops the
// queue and compares every decoded frame with the frame built from the byte.
// Frame start times are logged so that latency and contiguity can be checked.

module tb_uart_transmitter;

  localparam int CLK_FREQ   = 1600;
  localparam int BAUD_RATE  = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int BP         = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS      = 11;
`else
  localparam int NBITS      = 10;
`endif
  localparam int FRAME_CLKS = NBITS * BP;

  logic       clk;
  logic       rst;
  logic       com_valid;
  logic [7:0] com_wdata;
  logic       com_ready;
  logic       uart_tx;
  logic       tx_busy;

  int         n_cmp;
  int         n_fail;
  int         cyc;
  int         last_accept_cyc;
  bit         mon_en;
  bit         abort_flag;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_transmitter #(
    .BAUD_RATE (BAUD_RATE),
    .CLK_FREQ  (CLK_FREQ),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .com_valid(com_valid),
    .com_wdata(com_wdata),
    .com_ready(com_ready),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  // Free-running clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // The frame as it should appear on the line: start bit, data bits LSB
  // first, the optional even parity bit, and the stop bit. Unused upper
  // bits stay at 1.
  function automatic logic [15:0] expected_frame(input logic [7:0] b);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: wait expired at cycle %0d", name, cyc);
  endtask

  // Offer one byte and hold it until it is accepted. The expected byte is
  // queued, and the accepting cycle number is recorded.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    com_valid = 1'b1;
    com_wdata = b;
    while (!com_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!com_ready) begin
      timeoutFail("accept_timeout");
      com_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(b);
    #1;
    last_accept_cyc = cyc;
    com_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int waited;
    waited = 0;
    @(negedge clk);
    while (tx_busy && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (tx_busy) timeoutFail(name);
    repeat (4) @(negedge clk);
  endtask

  // Line monitor: detects a start bit, samples every bit at its middle, and
  // checks the decoded frame against the scoreboard. A reset during a frame
  // abandons that frame.
  initial begin
    logic [15:0] rx;
    logic [7:0]  exp_b;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (abort_flag) begin
        abort_flag = 1'b0;
      end else if (mon_en && uart_tx == 1'b0) begin
        start_q.push_back(cyc);
        rx = '1;
        aborted = 1'b0;
        for (int c = 1; c <= BP * (NBITS - 1) + BP / 2; c++) begin
          @(negedge clk);
          if (abort_flag) begin
            abort_flag = 1'b0;
            aborted = 1'b1;
            break;
          end
          if (c % BP == BP / 2) rx[c / BP] = uart_tx;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            timeoutFail("unexpected_frame");
          end else begin
            exp_b = exp_q.pop_front();
            checkOutput("frame_bits", int'(rx), int'(expected_frame(exp_b)));
          end
        end
      end
    end
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_acc;
    int accepted;
    int ready_back;
    int low_cnt;
    int iter;
    int idx;
    bit saw_full;
    bit rdy;
    logic [7:0] burst [6];

    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    mon_en = 1'b0;
    abort_flag = 1'b0;
    com_valid = 1'b0;
    com_wdata = 8'h00;
    rst = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_uart_tx", int'(uart_tx), 1);
    checkOutput("reset_com_ready", int'(com_ready), 1);
    checkOutput("reset_tx_busy", int'(tx_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte from idle: latency, frame contents, and busy duration
    $display("[TB] single byte 0xA5");
    start_q.delete();
    applyStimulus(8'hA5);
    first_acc = last_accept_cyc;
    iter = 0;
    @(negedge clk);
    while (tx_busy && iter < 1000) begin
      @(negedge clk);
      iter++;
    end
    if (tx_busy) timeoutFail("single_busy_timeout");
    else checkOutput("single_busy_drop", cyc, first_acc + 1 + FRAME_CLKS);
    repeat (4) @(negedge clk);
    if (start_q.size() != 1) timeoutFail("single_frame_count");
    else checkOutput("single_start_latency", start_q[0], first_acc + 2);

    // Burst of six bytes with com_valid held high
    $display("[TB] burst 0x01..0x06");
    start_q.delete();
    for (int i = 0; i < 6; i++) burst[i] = 8'(i + 1);
    idx = 0;
    accepted = 0;
    saw_full = 1'b0;
    ready_back = -1;
    first_acc = 0;
    iter = 0;
    @(negedge clk);
    com_valid = 1'b1;
    while (idx < 6 && iter < 3000) begin
      com_wdata = burst[idx];
      rdy = com_ready;
      if (saw_full && rdy && ready_back < 0) ready_back = cyc;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(burst[idx]);
        #1;
        if (idx == 0) first_acc = cyc;
        if (!saw_full) accepted++;
        idx++;
      end else begin
        saw_full = 1'b1;
      end
      @(negedge clk);
      iter++;
    end
    com_valid = 1'b0;
    checkOutput("burst_accepted_before_full", accepted, FIFO_DEPTH + 1);
    checkOutput("burst_ready_return", ready_back, first_acc + 1 + FRAME_CLKS);
    waitIdle("burst_idle_timeout");
    if (start_q.size() != 6) begin
      timeoutFail("burst_frame_count");
    end else begin
      for (int k = 0; k < 6; k++)
        checkOutput($sformatf("burst_start_%0d", k), start_q[k], first_acc + 2 + k * FRAME_CLKS);
      checkOutput("burst_total_clocks", start_q[5] + FRAME_CLKS - start_q[0], 6 * FRAME_CLKS);
    end

    // Data-path corner values, followed by a third byte to time the gap
    $display("[TB] corners 0x00 / 0xFF");
    start_q.delete();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    waitIdle("corner_idle_timeout");
    if (start_q.size() != 3) begin
      timeoutFail("corner_frame_count");
    end else begin
      checkOutput("corner_gap_00_ff", start_q[1] - start_q[0], FRAME_CLKS);
      checkOutput("corner_gap_ff_next", start_q[2] - start_q[1], FRAME_CLKS);
    end

`ifdef UART_TX_PARITY_EN
    // Parity frames: the frame comparison covers the parity bit values
    $display("[TB] parity frames");
    start_q.delete();
    applyStimulus(8'hA5);
    applyStimulus(8'h07);
    waitIdle("parity_idle_timeout");
    if (start_q.size() != 2) timeoutFail("parity_frame_count");
    else checkOutput("parity_frame_length", start_q[1] - start_q[0], 11 * BP);
`endif

    // Reset during data bit 3, with two more bytes queued
    $display("[TB] reset mid-frame");
    start_q.delete();
    applyStimulus(8'h3C);
    first_acc = last_accept_cyc;
    applyStimulus(8'hC3);
    applyStimulus(8'h81);
    iter = 0;
    while (cyc < first_acc + 2 + 4 * BP + 5 && iter < 1000) begin
      @(negedge clk);
      iter++;
    end
    abort_flag = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    checkOutput("midreset_uart_tx", int'(uart_tx), 1);
    checkOutput("midreset_tx_busy", int'(tx_busy), 0);
    checkOutput("midreset_com_ready", int'(com_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    low_cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (uart_tx == 1'b0 || tx_busy) low_cnt++;
    end
    checkOutput("midreset_no_more_frames", low_cnt, 0);

    // Randomised bytes with random spacing
    $display("[TB] random traffic");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    waitIdle("random_idle_timeout");
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
